// File: rtl/mmio_responder_pkg.sv
// Shared constants and types for the memory-mapped responder page.
// Offsets are relative to the decoded page; STATUS layout is captured as a packed struct.
package mmio_pkg;

   localparam logic [3:0] OFF_TX       = 4'hC;
   localparam logic [3:0] OFF_STATUS   = 4'hD;
   localparam logic [3:0] OFF_RX       = 4'hE;
   localparam logic [3:0] OFF_TICK     = 4'hF;
   localparam logic [3:0] SCRATCH_LAST = 4'hB;

   localparam int NUM_SCRATCH = 12;
   localparam int CNT_W       = 3;

   localparam int ST_TX_OVF = 7;
   localparam int ST_RX_OVF = 6;

   typedef struct packed {
      logic             tx_ovf;
      logic             rx_ovf;
      logic [CNT_W-1:0] rx_count;
      logic [CNT_W-1:0] tx_count;
   } status_t;

endpackage

// File: rtl/mmio_responder_if.sv
// Bus and stream handshake signals between the processor side and the responder.
// The shared data bus stays a plain inout port on the responder itself.
interface mmio_responder_if;
   logic [7:0] address;
   logic       we;
   logic       sel;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output address, we, tx_ready, rx_data, rx_valid,
      input  sel, tx_data, tx_valid, rx_ready
   );

   modport slave (
      input  address, we, tx_ready, rx_data, rx_valid,
      output sel, tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/mmio_responder_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// is accepted only when a pop retires an entry on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [2:0]       count,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 2) ? 2 : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [2:0]       count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == 3'd0);
   assign full    = (count_reg == 3'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_reg;
   // Storage is not cleared on reset, so the head is masked while empty.
   assign dout    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end
endmodule

// File: rtl/mmio_responder.sv
// Responder for one 16-byte data page: scratch registers, TX/RX FIFOs,
// sticky overflow status and a free-running tick, read combinationally like RAM.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [3:0] PAGE  = 4'hF,
   parameter int         DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   inout  wire  [7:0]        data,
   mmio_responder_if.slave   bus
);
   logic [3:0] offset;
   logic       wr;
   logic       wr_tx;
   logic       wr_status;
   logic       wr_tick;
   logic [7:0] rd_value;
   status_t    status_word;

   logic [NUM_SCRATCH-1:0][7:0] scratch_val;

   logic [7:0] tx_head;
   logic [2:0] tx_count;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_pop;
   logic       tx_ovf_set;

   logic [7:0] rx_head;
   logic [2:0] rx_count;
   logic       rx_full;
   logic       rx_empty;
   logic       rx_push;
   logic       rx_at_data;
   logic       rx_dwell_end;
   logic       rx_ovf_set;

   logic       rx_dwell_reg;
   logic       tx_ovf_reg;
   logic       rx_ovf_reg;
   logic [7:0] tick_reg;

   assign offset    = bus.address[3:0];
   assign bus.sel   = (bus.address[7:4] == PAGE);
   assign wr        = bus.we && bus.sel;
   assign wr_tx     = wr && (offset == OFF_TX);
   assign wr_status = wr && (offset == OFF_STATUS);
   assign wr_tick   = wr && (offset == OFF_TICK);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
         logic [7:0] value_reg;
         always_ff @(posedge clock or posedge reset) begin
            if (reset)                          value_reg <= '0;
            else if (wr && offset == 4'(gi))    value_reg <= data;
         end
         assign scratch_val[gi] = value_reg;
      end
   endgenerate

   // A push that finds the FIFO full only succeeds if the consumer drains one on the same edge.
   assign tx_pop     = bus.tx_ready && !tx_empty;
   assign tx_ovf_set = wr_tx && tx_full && !tx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_tx),
      .pop   (tx_pop),
      .din   (data),
      .dout  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign bus.tx_data  = tx_head;
   assign bus.tx_valid = !tx_empty;

   // The pop fires when the bus leaves the RX address, so a dwell of any length pops once.
   assign rx_at_data   = (bus.address == {PAGE, OFF_RX});
   assign rx_dwell_end = rx_dwell_reg && !rx_at_data;
   assign rx_ovf_set   = rx_dwell_end && rx_empty;
   assign rx_push      = bus.rx_valid && !rx_full;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_dwell_end),
      .din   (bus.rx_data),
      .dout  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign bus.rx_ready = !rx_full;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_dwell_reg <= 1'b0;
         tx_ovf_reg   <= 1'b0;
         rx_ovf_reg   <= 1'b0;
         tick_reg     <= '0;
      end else begin
         rx_dwell_reg <= rx_at_data;
         tx_ovf_reg   <= tx_ovf_set | (tx_ovf_reg & ~(wr_status & data[ST_TX_OVF]));
         rx_ovf_reg   <= rx_ovf_set | (rx_ovf_reg & ~(wr_status & data[ST_RX_OVF]));
         tick_reg     <= wr_tick ? data : tick_reg + 8'd1;
      end
   end

   assign status_word = '{tx_ovf: tx_ovf_reg, rx_ovf: rx_ovf_reg,
                          rx_count: rx_count, tx_count: tx_count};

   always_comb begin
      rd_value = '0;
      if (offset <= SCRATCH_LAST) begin
         rd_value = scratch_val[offset];
      end else begin
         case (offset)
            OFF_STATUS: rd_value = status_word;
            OFF_RX:     rd_value = rx_head;
            OFF_TICK:   rd_value = tick_reg;
            default:    rd_value = '0;
         endcase
      end
   end

   assign data = (bus.sel && !bus.we) ? rd_value : 8'hzz;
endmodule

// File: tb/tb_mmio_responder.sv
// Directed and randomized bus traffic checked against a queue-based model of the responder page.
module tb_mmio_responder;
   localparam int DEPTH = 4;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic       drv_en  = 1'b0;
   logic [7:0] drv_val = 8'h00;
   wire  [7:0] data;

   assign data = drv_en ? drv_val : 8'hzz;

   mmio_responder_if bus ();

   mmio_responder #(.PAGE(4'hF), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .data  (data),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state
   logic [7:0] m_scr [12];
   logic [7:0] m_tx [$];
   logic [7:0] m_rx [$];
   logic       m_txovf;
   logic       m_rxovf;
   logic [7:0] m_tick;
   logic [7:0] m_prev;

   logic [7:0] last_rd;
   logic [7:0] last_txd;
   logic       last_txv;
   logic       last_rxr;
   logic       last_sel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 12; i++) m_scr[i] = 8'h00;
      m_tx.delete();
      m_rx.delete();
      m_txovf = 1'b0;
      m_rxovf = 1'b0;
      m_tick  = 8'h00;
      m_prev  = 8'h00;
   endtask

   function automatic logic [7:0] m_read(input logic [3:0] off);
      if (off <= 4'hB) return m_scr[off];
      case (off)
         4'hC:    return 8'h00;
         4'hD:    return {m_txovf, m_rxovf, 3'(m_rx.size()), 3'(m_tx.size())};
         4'hE:    return (m_rx.size() != 0) ? m_rx[0] : 8'h00;
         default: return m_tick;
      endcase
   endfunction

   // One rising edge of the page, applying the rules to the inputs present at that edge.
   task automatic model_edge();
      logic [7:0] a;
      logic       wr;
      logic       rx_can_push;
      logic       set_tx;
      logic       set_rx;
      a           = bus.address;
      wr          = bus.we && (a[7:4] == 4'hF);
      rx_can_push = bus.rx_valid && (m_rx.size() < DEPTH);
      set_tx      = 1'b0;
      set_rx      = 1'b0;

      if (bus.tx_ready && m_tx.size() != 0) void'(m_tx.pop_front());
      if (wr && a[3:0] == 4'hC) begin
         if (m_tx.size() < DEPTH) m_tx.push_back(drv_val);
         else set_tx = 1'b1;
      end

      if (m_prev == 8'hFE && a != 8'hFE) begin
         if (m_rx.size() != 0) void'(m_rx.pop_front());
         else set_rx = 1'b1;
      end
      if (rx_can_push) m_rx.push_back(bus.rx_data);

      if (wr && a[3:0] == 4'hD) begin
         if (drv_val[7]) m_txovf = 1'b0;
         if (drv_val[6]) m_rxovf = 1'b0;
      end
      if (set_tx) m_txovf = 1'b1;
      if (set_rx) m_rxovf = 1'b1;

      if (wr && a[3:0] <= 4'hB) m_scr[a[3:0]] = drv_val;
      if (wr && a[3:0] == 4'hF) m_tick = drv_val;
      else m_tick = m_tick + 8'd1;

      m_prev = a;
   endtask

   task automatic set_bus(input logic [7:0] addr, input logic we, input logic [7:0] wdata);
      bus.address = addr;
      bus.we      = we;
      drv_en      = we || (addr[7:4] != 4'hF);
      drv_val     = we ? wdata : 8'hC3;
   endtask

   task automatic do_cycle();
      logic in_page;
      @(negedge clock);
      in_page  = (bus.address[7:4] == 4'hF);
      last_rd  = data;
      last_txd = bus.tx_data;
      last_txv = bus.tx_valid;
      last_rxr = bus.rx_ready;
      last_sel = bus.sel;
      check("sel", bus.sel, in_page);
      check("tx_valid", bus.tx_valid, m_tx.size() != 0);
      check("tx_data", bus.tx_data, (m_tx.size() != 0) ? m_tx[0] : 8'h00);
      check("rx_ready", bus.rx_ready, m_rx.size() < DEPTH);
      if (in_page && !bus.we) check("rd_data", data, m_read(bus.address[3:0]));
      else                    check("bus_float", data, drv_val);
      $display("cyc=%0d addr=%02h we=%0b data=%02h txv=%0b txd=%02h txr=%0b rxv=%0b rxr=%0b",
               cyc, bus.address, bus.we, data, bus.tx_valid, bus.tx_data,
               bus.tx_ready, bus.rx_valid, bus.rx_ready);
      @(posedge clock);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic bus_op(input logic [7:0] addr, input logic we, input logic [7:0] wdata);
      set_bus(addr, we, wdata);
      do_cycle();
   endtask

   initial begin
      logic [7:0] ra;
      logic       rw;

      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      set_bus(8'h00, 1'b0, 8'h00);
      model_reset();

      repeat (2) @(posedge clock);
      #1;
      check("reset_tx_valid", bus.tx_valid, 1'b0);
      check("reset_rx_ready", bus.rx_ready, 1'b1);
      check("reset_tx_data", bus.tx_data, 8'h00);
      reset = 1'b0;

      // Scratch registers and bus release
      bus_op(8'hF3, 1'b1, 8'h5A);
      bus_op(8'hFB, 1'b1, 8'hA5);
      bus_op(8'hF3, 1'b0, 8'h00);
      check("scratch3", last_rd, 8'h5A);
      bus_op(8'hFB, 1'b0, 8'h00);
      check("scratch11", last_rd, 8'hA5);
      bus_op(8'hF3, 1'b1, 8'h00);
      check("we_no_drive", last_rd, 8'h00);
      bus_op(8'h13, 1'b0, 8'h00);
      check("off_page_sel", last_sel, 1'b0);
      check("off_page_float", last_rd, 8'hC3);

      // TICK load and wrap
      bus_op(8'hFF, 1'b1, 8'hFE);
      bus_op(8'hFF, 1'b0, 8'h00);
      check("tick_fe", last_rd, 8'hFE);
      bus_op(8'hFF, 1'b0, 8'h00);
      check("tick_ff", last_rd, 8'hFF);
      bus_op(8'hFF, 1'b0, 8'h00);
      check("tick_wrap", last_rd, 8'h00);

      // TX overflow and drain
      for (int i = 1; i <= 5; i++) bus_op(8'hFC, 1'b1, 8'(i));
      bus_op(8'hFD, 1'b0, 8'h00);
      check("status_txovf", last_rd, 8'h84);
      bus.tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus_op(8'hF0, 1'b0, 8'h00);
         check("tx_order", last_txd, 8'(i));
      end
      bus_op(8'hF0, 1'b0, 8'h00);
      check("tx_drained", last_txv, 1'b0);
      bus.tx_ready = 1'b0;
      bus_op(8'hFD, 1'b1, 8'h80);
      bus_op(8'hFD, 1'b0, 8'h00);
      check("status_w1c", last_rd, 8'h00);

      // RX dwell pops and underflow
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h11;
      bus_op(8'hF0, 1'b0, 8'h00);
      bus.rx_data  = 8'h22;
      bus_op(8'hF0, 1'b0, 8'h00);
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_op(8'hFE, 1'b0, 8'h00);
         check("rx_dwell1", last_rd, 8'h11);
      end
      bus_op(8'hF0, 1'b0, 8'h00);
      for (int i = 0; i < 2; i++) begin
         bus_op(8'hFE, 1'b0, 8'h00);
         check("rx_dwell2", last_rd, 8'h22);
      end
      bus_op(8'hF0, 1'b0, 8'h00);
      bus_op(8'hFE, 1'b0, 8'h00);
      check("rx_empty_read", last_rd, 8'h00);
      bus_op(8'hF0, 1'b0, 8'h00);
      bus_op(8'hFD, 1'b0, 8'h00);
      check("status_rxovf", last_rd, 8'h40);
      bus_op(8'hFD, 1'b1, 8'h40);

      // Full-FIFO simultaneity
      for (int i = 0; i < 4; i++) bus_op(8'hFC, 1'b1, 8'h31 + 8'(i));
      bus.tx_ready = 1'b1;
      bus_op(8'hFC, 1'b1, 8'h77);
      bus.tx_ready = 1'b0;
      bus_op(8'hFD, 1'b0, 8'h00);
      check("tx_full_push_pop", last_rd, 8'h04);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_op(8'hF0, 1'b0, 8'h00);
         check("tx_after_swap", last_txd, (i == 3) ? 8'h77 : 8'h32 + 8'(i));
      end
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.rx_data = 8'hA0 + 8'(i);
         bus_op(8'hF0, 1'b0, 8'h00);
      end
      bus.rx_data = 8'hEE;
      bus_op(8'hF0, 1'b0, 8'h00);
      check("rx_full_ready", last_rxr, 1'b0);
      bus.rx_valid = 1'b0;
      bus_op(8'hFD, 1'b0, 8'h00);
      check("rx_full_status", last_rd, 8'h20);
      bus_op(8'hFE, 1'b0, 8'h00);
      check("rx_full_head", last_rd, 8'hA0);
      bus_op(8'hF0, 1'b0, 8'h00);

      // Randomized traffic with dwell bias
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 0)      ra = bus.address;
         else if ($urandom_range(0, 9) < 8)  ra = {4'hF, 4'($urandom_range(0, 15))};
         else                                ra = 8'($urandom);
         rw = ($urandom_range(0, 3) == 0);
         bus.tx_ready = 1'($urandom_range(0, 1));
         bus.rx_valid = 1'($urandom_range(0, 1));
         bus.rx_data  = 8'($urandom);
         bus_op(ra, rw, 8'($urandom));
      end

      // Asynchronous reset mid-dwell with RX full and TX occupied
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 8 && m_rx.size() < DEPTH; i++) begin
         bus.rx_data = 8'h90 + 8'(i);
         bus_op(8'hF0, 1'b0, 8'h00);
      end
      bus.rx_valid = 1'b0;
      bus_op(8'hFC, 1'b1, 8'h44);
      bus_op(8'hF5, 1'b1, 8'h66);
      bus_op(8'hFE, 1'b0, 8'h00);
      set_bus(8'hFE, 1'b0, 8'h00);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("arst_tx_valid", bus.tx_valid, 1'b0);
      check("arst_rx_ready", bus.rx_ready, 1'b1);
      check("arst_tx_data", bus.tx_data, 8'h00);
      set_bus(8'hFD, 1'b0, 8'h00);
      #1;
      check("arst_status", data, 8'h00);
      set_bus(8'hF5, 1'b0, 8'h00);
      #1;
      check("arst_scratch", data, 8'h00);
      set_bus(8'hFF, 1'b0, 8'h00);
      #1;
      check("arst_tick", data, 8'h00);
      set_bus(8'hF0, 1'b0, 8'h00);
      @(posedge clock);
      #1;
      reset = 1'b0;
      bus_op(8'hF0, 1'b0, 8'h00);
      bus_op(8'hF0, 1'b0, 8'h00);
      bus_op(8'hFD, 1'b0, 8'h00);
      check("post_reset_no_pop", last_rd, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
